// File: rtl/sd4_pp_gen.sv
// Sequential radix-4 signed-digit (Booth) partial-product generator: nine lanes, one digit per cycle.
// Optional early exit when all remaining digits are zero: define SD4_ZERO_SKIP_EN.
module sd4_pp_gen #(
    parameter int A_W  = 8,
    parameter int W_W  = 8,
    parameter int PP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9*A_W-1:0]  act,
    input  logic [9*W_W-1:0]  wgt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PP_W-1:0]   aligned_pp_0,
    output logic [PP_W-1:0]   aligned_pp_1,
    output logic [PP_W-1:0]   aligned_pp_2,
    output logic [PP_W-1:0]   aligned_pp_3,
    output logic [PP_W-1:0]   aligned_pp_4,
    output logic [PP_W-1:0]   aligned_pp_5,
    output logic [PP_W-1:0]   aligned_pp_6,
    output logic [PP_W-1:0]   aligned_pp_7,
    output logic [PP_W-1:0]   aligned_pp_8,
    output logic [1:0]        dbg_state
);

    localparam int LANES = 9;
    localparam int ND    = W_W / 2;
    localparam int K_W   = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [PP_W-1:0] ONE = PP_W'(1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid must not depend on ready, and the sender holds its data until the transfer.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [9*A_W-1:0] act_q, act_d;
    logic [9*W_W-1:0] wgt_q, wgt_d;
    logic [PP_W-1:0]  acc_q [LANES];
    logic [PP_W-1:0]  acc_d [LANES];
    logic [PP_W-1:0]  pp_q  [LANES];
    logic [PP_W-1:0]  pp_d  [LANES];
    logic             out_valid_q, out_valid_d;
    logic             last_digit;

    // Weighted term for digit k: the Booth triplet {w[2k+1], w[2k], w[2k-1]} selects 0, +-a or +-2a.
    function automatic logic [PP_W-1:0] sd4_term(input logic [A_W-1:0] a,
                                                 input logic [W_W-1:0] w,
                                                 input logic [K_W-1:0] k);
        logic [W_W:0]    wext;
        logic [2:0]      trip;
        logic [PP_W-1:0] a_ext;
        logic [PP_W-1:0] mag;
        wext  = {w, 1'b0};
        trip  = wext[2*k +: 3];
        a_ext = PP_W'($signed(a));
        case (trip)
            3'b001, 3'b010: mag = a_ext;
            3'b011:         mag = a_ext << 1;
            3'b100:         mag = ~(a_ext << 1) + ONE;
            3'b101, 3'b110: mag = ~a_ext + ONE;
            default:        mag = '0;
        endcase
        return mag << (2*k);
    endfunction

`ifdef SD4_ZERO_SKIP_EN
    // Remaining digits are zero when w[W_W-1:2k+1] is a pure sign extension.
    function automatic logic rest_zero(input logic [W_W-1:0] w, input logic [K_W-1:0] k);
        logic [W_W-1:0] s;
        s = W_W'($signed(w) >>> (2*k + 1));
        return (s == '0) || (s == '1);
    endfunction
`endif

    always_comb begin
        last_digit = (k_q == K_W'(ND - 1));
`ifdef SD4_ZERO_SKIP_EN
        begin
            logic all_rest;
            all_rest = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                all_rest = all_rest & rest_zero(wgt_q[i*W_W +: W_W], k_q);
            end
            last_digit = last_digit | all_rest;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        act_d       = act_q;
        wgt_d       = wgt_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        pp_d        = pp_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    act_d   = act;
                    wgt_d   = wgt;
                    k_d     = '0;
                    for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    acc_d[i] = acc_q[i] + sd4_term(act_q[i*A_W +: A_W], wgt_q[i*W_W +: W_W], k_q);
                end
                k_d = k_q + K_W'(1);
                if (last_digit) begin
                    pp_d        = acc_d;
                    out_valid_d = 1'b1;
                    k_d         = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            act_q       <= '0;
            wgt_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
                pp_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            act_q       <= act_d;
            wgt_q       <= wgt_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            pp_q        <= pp_d;
        end
    end

    // Ready is gated by rst so it reads low for the whole time reset is asserted.
    assign in_ready     = rst & (state_q == IDLE);
    assign out_valid    = out_valid_q;
    assign dbg_state    = state_q;
    assign aligned_pp_0 = pp_q[0];
    assign aligned_pp_1 = pp_q[1];
    assign aligned_pp_2 = pp_q[2];
    assign aligned_pp_3 = pp_q[3];
    assign aligned_pp_4 = pp_q[4];
    assign aligned_pp_5 = pp_q[5];
    assign aligned_pp_6 = pp_q[6];
    assign aligned_pp_7 = pp_q[7];
    assign aligned_pp_8 = pp_q[8];

endmodule

// File: tb/tb_sd4_pp_gen.sv
// Bench for sd4_pp_gen: directed corner cases plus random operand sets against a signed-multiply model.
// Expected latency follows SD4_ZERO_SKIP_EN when the macro is defined for the build.
module tb_sd4_pp_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [71:0]  act;
    logic [71:0]  wgt;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  pp [9];
    logic [1:0]   dbg_state;

    logic [7:0]   cur_a [9];
    logic [7:0]   cur_w [9];
    int           n_pass = 0;
    int           n_total = 0;

    sd4_pp_gen dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .act(act), .wgt(wgt), .out_valid(out_valid), .out_ready(out_ready),
        .aligned_pp_0(pp[0]), .aligned_pp_1(pp[1]), .aligned_pp_2(pp[2]),
        .aligned_pp_3(pp[3]), .aligned_pp_4(pp[4]), .aligned_pp_5(pp[5]),
        .aligned_pp_6(pp[6]), .aligned_pp_7(pp[7]), .aligned_pp_8(pp[8]),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_pp(input int i);
        int p;
        p = int'($signed(cur_a[i])) * int'($signed(cur_w[i]));
        return p[15:0];
    endfunction

    // Early exit after n digits is possible once every weight fits in 2n signed bits.
    function automatic int exp_lat();
`ifdef SD4_ZERO_SKIP_EN
        int wv;
        bit ok;
        for (int n = 1; n <= 4; n++) begin
            ok = 1'b1;
            for (int i = 0; i < 9; i++) begin
                wv = int'($signed(cur_w[i]));
                if (wv < -(1 << (2*n - 1)) || wv >= (1 << (2*n - 1))) ok = 1'b0;
            end
            if (ok) return n;
        end
        return 4;
`else
        return 4;
`endif
    endfunction

    task automatic set_all(input logic [7:0] a, input logic [7:0] w);
        for (int i = 0; i < 9; i++) begin
            cur_a[i] = a;
            cur_w[i] = w;
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < 9; i++) begin
            act[i*8 +: 8] = cur_a[i];
            wgt[i*8 +: 8] = cur_w[i];
        end
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // One full transaction; hold = cycles of backpressure with in_valid noise while DONE.
    task automatic run_op(input string tag, input int hold);
        int lat;
        logic [15:0] exp_pp [9];
        wait_ready(tag);
        drive_ops();
        for (int i = 0; i < 9; i++) exp_pp[i] = ref_pp(i);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat()));
        for (int i = 0; i < 9; i++) check($sformatf("%s pp%0d", tag, i), 32'(pp[i]), 32'(exp_pp[i]));
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1;
            act = {$urandom, $urandom, $urandom};
            wgt = {$urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check($sformatf("%s hold%0d valid", tag, c), 32'(out_valid), 32'd1);
            check($sformatf("%s hold%0d ready", tag, c), 32'(in_ready), 32'd0);
            check($sformatf("%s hold%0d pp8", tag, c), 32'(pp[8]), 32'(exp_pp[8]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " valid cleared"}, 32'(out_valid), 32'd0);
        check({tag, " idle ready"}, 32'(in_ready), 32'd1);
        check({tag, " pp0 kept"}, 32'(pp[0]), 32'(exp_pp[0]));
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        act       = '0;
        wgt       = '0;
        set_all(8'd0, 8'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset pp0", 32'(pp[0]), 32'd0);
        check("reset pp8", 32'(pp[8]), 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        set_all(8'd127, 8'd127);
        run_op("maxpos", 0);
        set_all(8'h80, 8'h80);
        run_op("maxneg", 0);
        set_all(8'd5, 8'hFD);
        run_op("mixed", 0);

        begin
            logic [7:0] wl [9];
            wl = '{8'h55, 8'hAA, 8'h7F, 8'h80, 8'h01, 8'hFF, 8'h33, 8'hCC, 8'h00};
            for (int i = 0; i < 9; i++) begin
                cur_a[i] = 8'(i - 4);
                cur_w[i] = wl[i];
            end
        end
        run_op("digits", 0);

        set_all(8'hF9, 8'd1);
        run_op("zeroskip", 0);

        set_all(8'hC3, 8'h5A);
        run_op("backpressure", 10);
        set_all(8'd9, 8'hF0);
        run_op("after_bp", 0);

        // Reset in the middle of a run discards the partial result.
        set_all(8'd3, 8'd3);
        wait_ready("midreset");
        drive_ops();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 9; i++) check($sformatf("midreset pp%0d", i), 32'(pp[i]), 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset release ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("midreset stale%0d", c), 32'(out_valid), 32'd0);
        end

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 9; i++) begin
                cur_a[i] = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) cur_w[i] = 8'($urandom_range(0, 255));
                else cur_w[i] = 8'($urandom_range(0, 7)) - 8'd4;
            end
            run_op($sformatf("rand%0d", t), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
